// File: rtl/cpu_control_hs_if.sv
// Control/handshake bundle between the multicycle controller and the lab CPU datapath.
// The master side is the controller; the slave side is the datapath and memory.
`timescale 1ns/1ps
interface cpu_control_hs_if #(
  parameter int OP_W     = 4,
  parameter int RF_SEL_W = 3,
  parameter int PC_SEL_W = 2
);
  logic                mem_wait;
  logic                mem_rddatavalid;
  logic                mem_rd;
  logic                mem_wr;
  logic                mem_addr_sel;
  logic [PC_SEL_W-1:0] pc_sel;
  logic                pc_ld;
  logic [OP_W:0]       ir;
  logic                ir_ld;
  logic [RF_SEL_W-1:0] rf_sel;
  logic                rf_write;
  logic                rf_addr_w_sel;
  logic                alu_n;
  logic                alu_z;
  logic                alu_n_ld;
  logic                alu_z_ld;
  logic                alu_b_sel;
  logic                alu_op;
  logic                retire;
  logic                halted;

  modport master (
    input  mem_wait, mem_rddatavalid, ir, alu_n, alu_z,
    output mem_rd, mem_wr, mem_addr_sel, pc_sel, pc_ld, ir_ld, rf_sel, rf_write,
           rf_addr_w_sel, alu_n_ld, alu_z_ld, alu_b_sel, alu_op, retire, halted
  );

  modport slave (
    output mem_wait, mem_rddatavalid, ir, alu_n, alu_z,
    input  mem_rd, mem_wr, mem_addr_sel, pc_sel, pc_ld, ir_ld, rf_sel, rf_write,
           rf_addr_w_sel, alu_n_ld, alu_z_ld, alu_b_sel, alu_op, retire, halted
  );
endinterface

// File: rtl/cpu_control_hs.sv
// Multicycle control FSM for the lab CPU: fetch/execute/load with a wait/rddatavalid
// memory handshake, illegal-opcode trapping and a one-cycle retire pulse.
`timescale 1ns/1ps
module cpu_control_hs #(
  parameter int OP_W            = 4,
  parameter int RF_SEL_W        = 3,
  parameter int PC_SEL_W        = 2,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  cpu_control_hs_if.master  bus
);

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_FWAIT = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_LWAIT = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [OP_W-1:0] OP_MV   = OP_W'(4'd0);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(4'd1);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(4'd2);
  localparam logic [OP_W-1:0] OP_CMP  = OP_W'(4'd3);
  localparam logic [OP_W-1:0] OP_LD   = OP_W'(4'd4);
  localparam logic [OP_W-1:0] OP_ST   = OP_W'(4'd5);
  localparam logic [OP_W-1:0] OP_MVHI = OP_W'(4'd6);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(4'd8);
  localparam logic [OP_W-1:0] OP_JZ   = OP_W'(4'd9);
  localparam logic [OP_W-1:0] OP_JN   = OP_W'(4'd10);
  localparam logic [OP_W-1:0] OP_CALL = OP_W'(4'd12);

  localparam logic [PC_SEL_W-1:0] PC_REG = PC_SEL_W'(2'd0);
  localparam logic [PC_SEL_W-1:0] PC_INC = PC_SEL_W'(2'd1);
  localparam logic [PC_SEL_W-1:0] PC_IMM = PC_SEL_W'(2'd2);

  localparam logic [RF_SEL_W-1:0] RF_IMM  = RF_SEL_W'(3'd0);
  localparam logic [RF_SEL_W-1:0] RF_HI   = RF_SEL_W'(3'd1);
  localparam logic [RF_SEL_W-1:0] RF_ALU  = RF_SEL_W'(3'd2);
  localparam logic [RF_SEL_W-1:0] RF_LINK = RF_SEL_W'(3'd3);
  localparam logic [RF_SEL_W-1:0] RF_MEM  = RF_SEL_W'(3'd4);
  localparam logic [RF_SEL_W-1:0] RF_REG  = RF_SEL_W'(3'd5);

  logic [2:0]          state;
  logic [2:0]          state_nx;
  logic [OP_W-1:0]     opcode;
  logic                imm;
  logic                rd, wr, addr_sel, pc_ld, ir_ld, rf_write, rf_addr_w_sel;
  logic                n_ld, z_ld, b_sel, alu_op, retire, halted;
  logic [PC_SEL_W-1:0] pc_sel;
  logic [RF_SEL_W-1:0] rf_sel;

  assign opcode = bus.ir[OP_W-1:0];
  assign imm    = bus.ir[OP_W];

  function automatic logic [PC_SEL_W-1:0] jump_sel(input logic imm_f);
    return imm_f ? PC_IMM : PC_REG;
  endfunction

  // Next-state and output decode; combinational so handshake strobes land in the accept cycle
  always_comb begin
    rd = 1'b0; wr = 1'b0; addr_sel = 1'b0; pc_ld = 1'b0; ir_ld = 1'b0;
    rf_write = 1'b0; rf_addr_w_sel = 1'b0; n_ld = 1'b0; z_ld = 1'b0;
    b_sel = 1'b0; alu_op = 1'b0; retire = 1'b0; halted = 1'b0;
    pc_sel = PC_REG; rf_sel = RF_IMM;
    state_nx = state;
    case (state)
      S_FETCH: begin
        rd = 1'b1;
        if (!bus.mem_wait) state_nx = S_FWAIT;
        else               state_nx = S_FETCH;
      end
      S_FWAIT: begin
        if (bus.mem_rddatavalid) begin
          ir_ld    = 1'b1;
          state_nx = S_EXEC;
        end else begin
          state_nx = S_FWAIT;
        end
      end
      S_EXEC: begin
        pc_sel = PC_INC; pc_ld = 1'b1; retire = 1'b1; state_nx = S_FETCH;
        case (opcode)
          OP_MV: begin
            rf_write = 1'b1;
            rf_sel   = imm ? RF_IMM : RF_REG;
          end
          OP_ADD, OP_SUB, OP_CMP: begin
            rf_write = (opcode != OP_CMP);
            rf_sel   = RF_ALU;
            n_ld     = 1'b1;
            z_ld     = 1'b1;
            alu_op   = (opcode != OP_ADD);
            b_sel    = ~imm;
          end
          OP_LD: begin
            rd = 1'b1; addr_sel = 1'b1; retire = 1'b0;
            if (bus.mem_wait) begin
              pc_ld = 1'b0; pc_sel = PC_REG; state_nx = S_EXEC;
            end else begin
              state_nx = S_LWAIT;
            end
          end
          OP_ST: begin
            wr = 1'b1; addr_sel = 1'b1;
            if (bus.mem_wait) begin
              pc_ld = 1'b0; pc_sel = PC_REG; retire = 1'b0; state_nx = S_EXEC;
            end else begin
              state_nx = S_FETCH;
            end
          end
          OP_MVHI: begin
            rf_write = 1'b1;
            rf_sel   = RF_HI;
          end
          OP_J: pc_sel = jump_sel(imm);
          OP_JZ: begin
            if (bus.alu_z) pc_sel = jump_sel(imm);
            else           pc_sel = PC_INC;
          end
          OP_JN: begin
            if (bus.alu_n) pc_sel = jump_sel(imm);
            else           pc_sel = PC_INC;
          end
          OP_CALL: begin
            pc_sel        = jump_sel(imm);
            rf_write      = 1'b1;
            rf_sel        = RF_LINK;
            rf_addr_w_sel = 1'b1;
          end
          default: begin
            if (HALT_ON_ILLEGAL) begin
              pc_sel = PC_REG; pc_ld = 1'b0; retire = 1'b0; state_nx = S_HALT;
            end else begin
              state_nx = S_FETCH;
            end
          end
        endcase
      end
      S_LWAIT: begin
        if (bus.mem_rddatavalid) begin
          rf_write = 1'b1; rf_sel = RF_MEM; retire = 1'b1; state_nx = S_FETCH;
        end else begin
          state_nx = S_LWAIT;
        end
      end
      S_HALT: begin
        halted   = 1'b1;
        state_nx = S_HALT;
      end
      default: state_nx = S_FETCH;
    endcase
  end

  // State register; a reset drops any outstanding memory request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  assign bus.mem_rd        = rd & ~rst;
  assign bus.mem_wr        = wr & ~rst;
  assign bus.mem_addr_sel  = addr_sel & ~rst;
  assign bus.pc_sel        = rst ? PC_REG : pc_sel;
  assign bus.pc_ld         = pc_ld & ~rst;
  assign bus.ir_ld         = ir_ld & ~rst;
  assign bus.rf_sel        = rst ? RF_IMM : rf_sel;
  assign bus.rf_write      = rf_write & ~rst;
  assign bus.rf_addr_w_sel = rf_addr_w_sel & ~rst;
  assign bus.alu_n_ld      = n_ld & ~rst;
  assign bus.alu_z_ld      = z_ld & ~rst;
  assign bus.alu_b_sel     = b_sel & ~rst;
  assign bus.alu_op        = alu_op & ~rst;
  assign bus.retire        = retire & ~rst;
  assign bus.halted        = halted & ~rst;

endmodule
